// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Write-side loader for the core's 32-word instruction memory. It receives a
//   length-prefixed byte stream over a valid/ready interface: one byte N
//   (1..32 words), followed by 4*N bytes. Every four bytes are assembled
//   little-endian into one 32-bit word, and that word is issued as a
//   single-cycle RAM write. The core is held in reset (cpu_rst_n low) until a
//   load completes successfully.
//
//   Optional build macro: IMEM_LOADER_NOP_FILL_EN
//     When it is defined, the words after the last loaded word are written
//     with NOP_WORD, so the rest of the memory holds NOPs. When it is not
//     defined, words that were not loaded keep their previous contents.
//
// Ports
//   clk        in   system clock (all state changes on the rising edge)
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse that begins a load (ignored while busy)
//   rx_data    in   [7:0] incoming byte
//   rx_valid   in   rx_data is valid
//   rx_ready   out  loader accepts a byte (LEN/DATA states)
//   wr_en      out  instruction RAM write strobe, one cycle per word
//   wr_addr    out  [ADDR_W-1:0] byte address of the written word ([1:0]=0)
//   wr_data    out  [31:0] written word
//   cpu_rst_n  out  core reset, released only after a successful load
//   busy       out  load in progress
//   done       out  last load completed successfully (level)
//   err        out  last load rejected because of a bad length byte (level)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int          WORDS_LOG2 = 5,             // memory depth = 2**WORDS_LOG2 words
  parameter int          ADDR_W     = 7,             // must equal WORDS_LOG2+2
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013  // addi x0,x0,0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // The length counter must hold values up to and including 2**WORDS_LOG2.
  // The length arrives as a single byte, so WORDS_LOG2 must be 7 or less.
  localparam int               LEN_W     = WORDS_LOG2 + 1;
  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(1) << WORDS_LOG2;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef IMEM_LOADER_NOP_FILL_EN
    S_FILL  = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [WORDS_LOG2-1:0]   idx_q,   idx_d;    // word index being written
  logic [1:0]              bcnt_q,  bcnt_d;   // byte position within word
  logic [LEN_W-1:0]        len_q,   len_d;    // word count N
  logic [31:0]             asm_q,   asm_d;    // word assembly register
  logic [ADDR_W-1:0]       addr_q,  addr_d;   // last written address (held)
  logic [31:0]             data_q,  data_d;   // last written data (held)

  logic last_word;
  logic idx_top;
  logic len_ok;
  logic in_fill;

  assign last_word = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
  assign idx_top   = &idx_q;
  assign len_ok    = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);

`ifdef IMEM_LOADER_NOP_FILL_EN
  assign in_fill = (state_q == S_FILL);
`else
  assign in_fill = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    len_d     = len_q;
    asm_d     = asm_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rx_ready  = 1'b0;
    busy      = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = addr_q;
    wr_data   = data_q;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst_n = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        done      = (state_q == S_DONE);
        err       = (state_q == S_ERR);
        cpu_rst_n = (state_q == S_DONE);
        if (start) begin
          state_d = S_LEN;
          idx_d   = '0;
          bcnt_d  = '0;
        end
      end

      S_LEN: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          if (len_ok) begin
            len_d   = LEN_W'(rx_data);
            state_d = S_DATA;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          asm_d[{bcnt_q, 3'b000} +: 8] = rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_NOP_FILL_EN
          // A full image (N = max) leaves nothing to fill.
          if (idx_top) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FILL;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          bcnt_d  = '0;
          state_d = S_DATA;
        end
      end

`ifdef IMEM_LOADER_NOP_FILL_EN
      S_FILL: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (idx_top) state_d = S_DONE;
        else         idx_d   = idx_q + 1'b1;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // The write port shows the current word while a write is issued. At all
    // other times it holds the last written address and data.
    if (wr_en) begin
      wr_addr = ADDR_W'({idx_q, 2'b00});
      wr_data = in_fill ? NOP_WORD : asm_q;
      addr_d  = wr_addr;
      data_d  = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bcnt_q  <= '0;
      len_q   <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed testbench for imem_loader. Each task drives one scenario and
//   checks the outputs against hand-computed expected values. A monitor
//   records every write; the tasks check that record by position.
//   Expected values depend on IMEM_LOADER_NOP_FILL_EN in the same way the
//   design does.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_LOADER_NOP_FILL_EN
  localparam int WR_N1 = 32;   // writes produced by an N=1 load
`else
  localparam int WR_N1 = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [6:0]  log_a[$];
  logic [31:0] log_d[$];

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_a.push_back(wr_addr);
      log_d.push_back(wr_data);
    end
  end

  // Each task starts and ends at #1 after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a byte and wait for it to be accepted. rx_valid stays high so
  // that consecutive calls stream the bytes with no gap between them.
  task automatic send_byte(input logic [7:0] b);
    int   t;
    logic rdy;
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk); rdy = rx_ready;
      @(posedge clk); t++;
    end while (rdy !== 1'b1 && t < 100);
    #1;
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_err++;
      $display("FAIL send_byte_timeout: byte %h never accepted (rx_ready=%b, required 1)", b, rdy);
    end
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    do begin
      @(negedge clk); t++;
    end while (done !== 1'b1 && t < 80);
    n_cmp++;
    if ({done, cpu_rst_n, busy} !== 3'b110) begin
      n_err++;
      $display("FAIL %s_done: done/cpu_rst_n/busy=%b required 110", tag, {done, cpu_rst_n, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err, rx_ready} !== 46'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0",
               {wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err, rx_ready});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({cpu_rst_n, busy, done, err, rx_ready, wr_en} !== 6'd0) begin
      n_err++;
      $display("FAIL idle_outputs: got %b required 000000",
               {cpu_rst_n, busy, done, err, rx_ready, wr_en});
    end
  endtask

  // N=1 load: checks write latency, the write itself, the fill writes, and
  // that the port holds its last values after the load.
  task automatic test_single();
    int         base;
    logic [7:0] b[5] = '{8'h01, 8'h13, 8'h06, 8'hB0, 8'h0B};
    base = log_a.size();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(b[i]);
    rx_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, rx_ready} !== {1'b1, 7'h00, 32'h0BB00613, 1'b0}) begin
      n_err++;
      $display("FAIL single_write: en/addr/data/rdy=%b/%h/%h/%b required 1/00/0bb00613/0",
               wr_en, wr_addr, wr_data, rx_ready);
    end
`ifdef IMEM_LOADER_NOP_FILL_EN
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({wr_en, wr_addr, wr_data, busy} !== {1'b1, 7'(i * 4), NOP, 1'b1}) begin
        n_err++;
        $display("FAIL fill_write%0d: en/addr/data=%b/%h/%h required 1/%h/%h",
                 i, wr_en, wr_addr, wr_data, 7'(i * 4), NOP);
      end
    end
`endif
    @(negedge clk);
    n_cmp++;
    if ({done, cpu_rst_n, busy, wr_en, err} !== 5'b11000) begin
      n_err++;
      $display("FAIL single_done: done/cpu_rst_n/busy/wr_en/err=%b required 11000",
               {done, cpu_rst_n, busy, wr_en, err});
    end
    n_cmp++;
`ifdef IMEM_LOADER_NOP_FILL_EN
    if ({wr_addr, wr_data} !== {7'h7C, NOP}) begin
`else
    if ({wr_addr, wr_data} !== {7'h00, 32'h0BB00613}) begin
`endif
      n_err++;
      $display("FAIL single_hold: addr/data=%h/%h not holding the last write", wr_addr, wr_data);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (log_a.size() - base !== WR_N1) begin
      n_err++;
      $display("FAIL single_wr_count: got %0d writes required %0d", log_a.size() - base, WR_N1);
    end
    @(posedge clk); #1;
  endtask

  // N=32 with a continuous stream: full image, minimum load time, no fill.
  task automatic test_full32();
    int base, c0, t;
    base = log_a.size();
    pulse_start();
    send_byte(8'h20);
    c0 = cyc;
    for (int i = 0; i < 32; i++) begin
      send_byte(8'(8'h13 + i));
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    end
    rx_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (done !== 1'b1 && t < 40);
    n_cmp++;
    if (done !== 1'b1 || (cyc - c0) !== 160) begin
      n_err++;
      $display("FAIL full32_latency: done=%b after %0d cycles required done=1 after 160",
               done, cyc - c0);
    end
    n_cmp++;
    if (log_a.size() - base !== 32) begin
      n_err++;
      $display("FAIL full32_wr_count: got %0d writes required 32", log_a.size() - base);
    end
    for (int i = 0; i < 32 && base + i < log_a.size(); i++) begin
      n_cmp++;
      if ({log_a[base+i], log_d[base+i]} !== {7'(i * 4), 32'h13 + 32'(i)}) begin
        n_err++;
        $display("FAIL full32_word%0d: addr/data=%h/%h required %h/%h",
                 i, log_a[base+i], log_d[base+i], 7'(i * 4), 32'h13 + 32'(i));
      end
    end
    @(posedge clk); #1;
  endtask

  // A bad length is rejected, then a good load clears the error.
  task automatic test_bad_len();
    int base;
    base = log_a.size();
    pulse_start();
    send_byte(8'h21);
    rx_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({err, done, cpu_rst_n, rx_ready, busy, wr_en} !== 6'b100000) begin
      n_err++;
      $display("FAIL len21_err: err/done/cpu_rst_n/rdy/busy/wr_en=%b required 100000",
               {err, done, cpu_rst_n, rx_ready, busy, wr_en});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (log_a.size() !== base || err !== 1'b1) begin
      n_err++;
      $display("FAIL len21_nowrite: writes=%0d err=%b required 0 writes err=1",
               log_a.size() - base, err);
    end
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if ({err, busy, rx_ready} !== 3'b011) begin
      n_err++;
      $display("FAIL restart_clears_err: err/busy/rdy=%b required 011", {err, busy, rx_ready});
    end
    @(posedge clk); #1;
    send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    rx_valid = 1'b0;
    wait_done("recover");
    n_cmp++;
    if (log_a.size() - base !== WR_N1 || log_d[base] !== 32'hEFBEADDE || err !== 1'b0) begin
      n_err++;
      $display("FAIL recover_write: count=%0d data=%h err=%b required %0d/efbeadde/0",
               log_a.size() - base, log_d[base], err, WR_N1);
    end
    // N=0 is also rejected.
    pulse_start();
    send_byte(8'h00);
    rx_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({err, done, cpu_rst_n, busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL len00_err: err/done/cpu_rst_n/busy=%b required 1000",
               {err, done, cpu_rst_n, busy});
    end
    @(posedge clk); #1;
  endtask

  // rx_valid drops every other cycle, but is held high through a WRITE cycle.
  task automatic test_throttle();
    int         base;
    logic [7:0] b[8] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    base = log_a.size();
    pulse_start();
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      send_byte(b[i]);
      if (i == 3) begin
        rx_data = b[4];
        @(negedge clk);
        n_cmp++;
        if ({rx_ready, wr_en, rx_valid} !== 3'b011) begin
          n_err++;
          $display("FAIL write_cycle_ready: rdy/wr_en/valid=%b required 011",
                   {rx_ready, wr_en, rx_valid});
        end
        @(posedge clk); #1;
      end else if (i != 7) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b0;
    wait_done("throttle");
    n_cmp++;
    if (log_a.size() - base < 2 ||
        {log_a[base], log_d[base], log_a[base+1], log_d[base+1]} !==
        {7'h00, 32'hA4A3A2A1, 7'h04, 32'hB4B3B2B1}) begin
      n_err++;
      $display("FAIL throttle_words: count=%0d w0=%h w1=%h required a4a3a2a1/b4b3b2b1",
               log_a.size() - base, log_d[base], log_d[base+1]);
    end
  endtask

  // Reset in the middle of a load, then a clean load with a stray start pulse.
  task automatic test_reset_mid();
    int         base;
    logic [7:0] b[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    base = log_a.size();
    pulse_start();
    send_byte(8'h02);
    for (int i = 0; i < 6; i++) send_byte(b[i]);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err, rx_ready} !== 46'd0) begin
      n_err++;
      $display("FAIL async_reset_outputs: got %h required 0",
               {wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err, rx_ready});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (log_a.size() - base !== 1 || log_d[base] !== 32'h44332211) begin
      n_err++;
      $display("FAIL reset_partial: count=%0d w0=%h required 1/44332211",
               log_a.size() - base, log_d[base]);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    base = log_a.size();
    pulse_start();
    send_byte(8'h01);
    rx_valid = 1'b0;
    pulse_start();   // ignored while busy
    @(negedge clk);
    n_cmp++;
    if ({busy, rx_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL start_while_busy: busy/rdy=%b required 11", {busy, rx_ready});
    end
    @(posedge clk); #1;
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    rx_valid = 1'b0;
    wait_done("after_reset");
    n_cmp++;
    if (log_a.size() - base !== WR_N1 || {log_a[base], log_d[base]} !== {7'h00, 32'h00100093}) begin
      n_err++;
      $display("FAIL after_reset_write: count=%0d addr/data=%h/%h required %0d/00/00100093",
               log_a.size() - base, log_a[base], log_d[base], WR_N1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full32();
    test_bad_len();
    test_throttle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the core's 32-word instruction memory.
- Receives a length-prefixed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Issues one-cycle word writes to the instruction RAM, which the core reads through the existing 7-bit byte-address fetch port.
- Holds the core in reset (cpu_rst_n low) while loading; releases it when the image is complete.

Parameters:
- WORDS_LOG2, 5, log2 of instruction memory depth in words (32 words).
- ADDR_W, 7, byte-address width of the write port; must equal WORDS_LOG2+2.
- NOP_WORD, 32'h00000013, fill value (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid&&rx_ready on a clk edge.
- wr_en  out  1  instruction RAM write strobe, one cycle per word.
- wr_addr  out  ADDR_W  byte address of the word being written; bits [1:0] always 0.
- wr_data  out  32  word being written.
- cpu_rst_n  out  1  core reset, active-low; low while loading or after an error.
- busy  out  1  load in progress.
- done  out  1  level; last load completed successfully.
- err  out  1  level; last load rejected.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE. All outputs are 0, including cpu_rst_n, so the core stays in reset until the first successful load. Word index, byte counter, length and the assembly register are cleared.
- States: IDLE, LEN, DATA, WRITE, FILL, DONE, ERR.
- IDLE/DONE/ERR:
  - rx_ready=0, busy=0.
  - start=1 moves to LEN, clears done/err, drives cpu_rst_n=0 and clears word index and byte counter.
- LEN:
  - rx_ready=1, busy=1.
  - Accepted byte N in 1..32 is latched as the word count and the state moves to DATA.
  - N=0 or N>32 moves to ERR: err=1, no writes, cpu_rst_n stays 0.
- DATA:
  - rx_ready=1, busy=1.
  - Byte k (k=0..3) of the current word goes to assembly bits [8k+7:8k] (little-endian).
  - Acceptance of the 4th byte moves to WRITE.
  - Cycles with rx_valid=0 leave all state unchanged; there is no timeout.
- WRITE:
  - Exactly one cycle: wr_en=1, wr_addr=word_idx<<2, wr_data=assembled word, rx_ready=0.
  - If word_idx==N-1, go to FILL when NOP_FILL_EN is defined, else DONE.
  - Otherwise word_idx increments, the byte counter clears, and the state returns to DATA.
  - A byte held on rx_data during WRITE is not consumed; it is accepted on the first DATA cycle.
- FILL: see Optional Feature.
- DONE: done=1, cpu_rst_n=1, busy=0. cpu_rst_n rises on the clock edge entering DONE.
- Outside WRITE/FILL cycles: wr_en=0, and wr_addr/wr_data hold their last values.
- start while busy=1 is ignored.
- Latency: the WRITE cycle immediately follows the cycle in which the 4th byte is accepted. Minimum load time is 1+5N cycles from the first accepted byte when rx_valid is held high.
- Reset mid-load: all state is discarded and no further write is issued. Words already written stay in RAM; the loader does not clear them.

Optional Feature:
- Macro: IMEM_LOADER_NOP_FILL_EN.
- Defined: after the last loaded word, FILL writes NOP_WORD to every remaining address (word_idx+1 .. 31), one wr_en per cycle, rx_ready=0, busy=1. It then enters DONE.
  - When N=32, FILL is skipped and WRITE goes directly to DONE.
- Not defined: the FILL state does not exist; WRITE goes directly to DONE and unloaded words retain their previous contents.

Test Plan:
- Feature on, start, then bytes 01,13,06,B0,0B -> one write addr 0x00 data 0x0BB00613; then 31 writes addr 0x04..0x7C data 0x00000013 on consecutive cycles; then done=1, cpu_rst_n=1.
- N=0x20 followed by 128 bytes (word i = 0x00000013+i) -> 32 writes, last addr 0x7C data 0x00000032; no FILL writes; done=1.
- N=0x21 -> err=1, no wr_en ever, cpu_rst_n=0, rx_ready=0. Then start, 01, 4 bytes -> err clears and the load completes.
- N=0x00 -> err=1. Feature off, N=1 -> exactly one wr_en, then DONE.
- rx_valid toggled every other cycle and held during WRITE -> rx_ready=0 in the WRITE cycle, no byte lost or duplicated, correct words written.
- rst_n pulsed low after 6 data bytes -> outputs go to 0 asynchronously; no write for the partial word. A later full load succeeds; start pulsed during busy has no effect.
